uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_fifo write port between N_REQ byte-stream clients.
- Grants are round-robin, one packet at a time: a grant holds from the first byte to the byte flagged last.
- Forwards the granted client's bytes to the FIFO write port (wr_en/wr_data), throttled by the FIFO ready flag.
- A watchdog releases a grant whose client stalls mid-packet. The block sits between console/debug sources and uart_tx_fifo in the 25 MHz domain.

Parameters:
- N_REQ, 4, number of clients (2..8).
- TIMEOUT_CYC, 1023, idle cycles inside a grant before forced release (must be >= 1).
- CNT_W, 10, width of the watchdog counter (must hold TIMEOUT_CYC).

Ports:
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  N_REQ  per-client "byte available"; also serves as the arbitration request.
- req_data  in  8*N_REQ  packed client bytes; client i uses bits [8i+7:8i].
- req_last  in  N_REQ  per-client flag: the current byte ends the packet.
- req_ack  out  N_REQ  one-hot pulse: client's byte accepted this cycle.
- grant  out  N_REQ  one-hot registered grant; 0 when idle.
- grant_id  out  3  index of the granted client; 0 when idle.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse when the watchdog releases a grant.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  8  FIFO write data.
- fifo_ready  in  1  FIFO can accept a write this cycle (the FIFO's ready output).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, rr_ptr=0, watchdog=0.
  - Outputs are held for as long as rst_n stays low.
  - Reset mid-packet drops the grant immediately. No wr_en is issued in any cycle where rst_n is low.
- Transfer rule (combinational, from registered grant):
  - xfer = busy & req_valid[grant_id] & fifo_ready.
  - wr_en = xfer; wr_data = req_data[grant_id]; req_ack[grant_id] = xfer.
  - All other req_ack bits are 0. wr_data is don't-care when wr_en=0 but must be driven (no X).
- State machine:
  - IDLE → GRANT:
    - Taken when any req_valid bit is high.
    - Winner = first set bit searching from rr_ptr upward, modulo N_REQ.
    - grant/grant_id/busy are registered next cycle, so there is 1 cycle of arbitration latency.
    - No transfer occurs in IDLE.
  - GRANT → IDLE on xfer & req_last[grant_id]:
    - rr_ptr ← (grant_id+1) mod N_REQ.
    - grant clears next cycle.
    - Back-to-back packets therefore have a minimum of 1 IDLE cycle between last byte and next grant.
  - GRANT → IDLE on watchdog expiry:
    - The watchdog resets on every xfer.
    - It counts cycles where busy & !req_valid[grant_id]. Cycles with fifo_ready=0 and valid=1 are backpressure: they hold the count and do not increment it.
    - When the count reaches TIMEOUT_CYC, timeout pulses for one cycle, grant clears next cycle, and rr_ptr ← (grant_id+1) mod N_REQ.
- Fairness and validity:
  - Requests from non-granted clients are ignored during GRANT; clients hold valid/data until acked.
  - The grant never changes mid-packet except on watchdog expiry or reset.
  - A single-byte packet (valid & last together) is legal: 1 transfer, then IDLE.
  - grant_id wraps from N_REQ-1 to 0.
- Simultaneous events:
  - A request arriving in the same cycle as the current grant's last transfer is arbitrated in the following IDLE cycle.
  - If the watchdog would expire in the same cycle as an xfer, the xfer wins and the count resets.
- Ordering: bytes reach the FIFO in client order with no duplication or loss. Exactly one wr_en is issued per req_ack.

Test Plan:
- Reset, then client 0 sends 0x55, 0xAA, 0x12, 0x34 (last on 0x34) with fifo_ready=1.
  → grant=0001 one cycle after valid; 4 consecutive wr_en with data 55,AA,12,34; busy low one cycle after the 0x34 ack.
- Clients 0..3 all request 2-byte packets (0x10+i, 0x20+i) simultaneously, rr_ptr=0.
  → FIFO receives 10,20,11,21,12,22,13,23; grant order 0,1,2,3; 1 idle cycle between packets.
- Client 2 granted; fifo_ready held low for 2000 cycles with valid=1.
  → no wr_en, no timeout; the transfer completes when fifo_ready rises.
- Client 1 sends 0x41, then drops valid before last; TIMEOUT_CYC=8 for this test.
  → timeout pulses on the 8th idle cycle; grant clears; client 2, pending, is granted next.
- rst_n driven low for 1 cycle in the middle of a 4-byte packet from client 3.
  → wr_en=0 and grant=0 the next cycle; rr_ptr=0; the client-0 request pending after reset is granted first.
- Single-byte packets (valid & last) from clients 1 and 3 together, rr_ptr=2.
  → client 3 is served first, then client 1; exactly 2 wr_en.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the console/debug clients, the arbiter and the
// uart_tx_fifo write port.
//   req_valid/req_data/req_last : per-client byte offer (client i owns bits [8i+7:8i] of req_data)
//   req_ack                     : per-client one-hot "byte taken this cycle"
//   wr_en/wr_data               : FIFO write strobe and byte
//   fifo_ready                  : FIFO can take a write this cycle
// master = client/FIFO side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ack;
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               fifo_ready;

  modport master (
    output req_valid, req_data, req_last, fifo_ready,
    input  req_ack, wr_en, wr_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_ready,
    output req_ack, wr_en, wr_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-at-a-time arbiter sharing one uart_tx_fifo write port
// between N_REQ byte-stream clients, with a watchdog that releases a grant
// whose client stalls mid-packet.
//
// Ports:
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   bus      : client byte streams, acks and FIFO write port (slave modport)
//   grant    : one-hot registered grant, 0 when idle
//   grant_id : index of the granted client, 0 when idle
//   busy     : high while a grant is held
//   timeout  : one-cycle pulse when the watchdog releases a grant
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate among req_valid starting from rr_q
// GRANT | one client owns the write port until its last byte or timeout
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               timeout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic [N_REQ-1:0]   grant_d;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   gid_inc;
  logic [7:0]         data_arr [N_REQ];
  logic               any_req;
  logic               cur_valid;
  logic               cur_last;
  logic               in_grant;
  logic               xfer;
  logic               stall;
  logic               expire;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = bus.req_data[8*i +: 8];
    end
  end

  assign in_grant  = (state_q == GRANT);
  assign cur_valid = bus.req_valid[gid_q];
  assign cur_last  = bus.req_last[gid_q];
  assign any_req   = |bus.req_valid;

  // rst_n gating keeps the write port and the timeout pulse quiet in any
  // cycle where reset is asserted, even before the reset edge lands.
  assign xfer   = rst_n & in_grant & cur_valid & bus.fifo_ready;
  assign stall  = in_grant & ~cur_valid;
  assign expire = rst_n & stall & (wdog_q == CNT_W'(TIMEOUT_CYC - 1));

  assign gid_inc = (gid_q == IDX_W'(N_REQ - 1)) ? '0 : gid_q + IDX_W'(1);

  // Winner is the first requesting client at or above rr_q, wrapping.
  // Scanning from the far end down lets the nearest hit overwrite the rest.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDX_W'(idx);
      if (bus.req_valid[cand]) winner = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      wdog_q  <= '0;
      grant   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
      grant   <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    wdog_d  = wdog_q;
    grant_d = grant;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (any_req) begin
          state_d         = GRANT;
          gid_d           = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) begin
          // A transfer always beats a coincident watchdog expiry.
          wdog_d = '0;
          if (cur_last) begin
            state_d = IDLE;
            gid_d   = '0;
            rr_d    = gid_inc;
            grant_d = '0;
          end
        end else if (expire) begin
          state_d = IDLE;
          gid_d   = '0;
          rr_d    = gid_inc;
          grant_d = '0;
          wdog_d  = '0;
        end else if (stall) begin
          wdog_d = wdog_q + CNT_W'(1);
        end
        // valid & !fifo_ready is backpressure: count holds.
      end
      default: begin
        state_d = IDLE;
        gid_d   = '0;
        grant_d = '0;
        wdog_d  = '0;
      end
    endcase
  end

  always_comb begin
    bus.wr_en          = xfer;
    bus.wr_data        = data_arr[gid_q];
    bus.req_ack        = '0;
    bus.req_ack[gid_q] = xfer;
    timeout            = expire;
    busy               = in_grant;
    grant_id           = 3'(gid_q);
  end

endmodule
